// File: rtl/yqc_calc_pkg.sv
// Shared key codes, operation and FSM state encodings for the yqc calculator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package yqc_calc_pkg;

    localparam int KEY_W = 4;

    localparam logic [KEY_W-1:0] KEY_LOAD_A = 4'h0;
    localparam logic [KEY_W-1:0] KEY_LOAD_B = 4'h1;
    localparam logic [KEY_W-1:0] KEY_OP_ADD = 4'h2;
    localparam logic [KEY_W-1:0] KEY_EXEC   = 4'h3;
    localparam logic [KEY_W-1:0] KEY_OP_DIV = 4'h4;
    localparam logic [KEY_W-1:0] KEY_OP_SUB = 4'h5;
    localparam logic [KEY_W-1:0] KEY_OP_MUL = 4'h6;
    localparam logic [KEY_W-1:0] KEY_OP_MOD = 4'h7;
    localparam logic [KEY_W-1:0] KEY_CLEAR  = 4'h8;

    typedef enum logic [2:0] {ADD, SUB, MUL, DIV, MOD} op_t;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    function automatic logic op_is_div(input op_t op);
        return (op == DIV) || (op == MOD);
    endfunction

endpackage

// File: rtl/yqc_calc_iter.sv
// Iterative engine: shift-add multiply and restoring divide on one shared hi/lo register pair.
// Latency: WIDTH cycles after start; last is high during the final step cycle.
// Backpressure: none; a/b/op must stay stable while active, start reloads at any time.
module yqc_calc_iter
    import yqc_calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_lo,
    output logic             res_hi_nz,
    output logic [WIDTH-1:0] rem,
    output logic             last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic             active;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    // MUL: {hi,lo} starts as {0,b}; each step adds a into hi when lo[0] is set, then shifts right.
    assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);

    // DIV: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    // Remainder stays below b, so the low WIDTH bits of the subtraction are exact.
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, b});
    assign div_diff  = div_shift[WIDTH-1:0] - b;

    assign last      = active && (cnt == CW'(WIDTH - 1));
    assign res_lo    = lo;
    assign res_hi_nz = |hi;
    assign rem       = hi;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            hi     <= '0;
            lo     <= (op == MUL) ? b : a;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (op == MUL) begin
                hi <= mul_sum[WIDTH:1];
                lo <= {mul_sum[0], lo[WIDTH-1:1]};
            end else begin
                hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                lo <= {lo[WIDTH-2:0], div_ge};
            end
            cnt <= cnt + CW'(1);
            if (last) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/yqc_calc_seq.sv
// Key-driven calculator: 1-cycle add/sub, WIDTH+1-cycle mul/div/mod; YQC_CALC_CHAIN_EN feeds results back into A.
// Latency: done one edge after EXEC for add/sub/div-by-zero, WIDTH+1 edges after EXEC for mul/div/mod.
// Backpressure: while busy every key except CLEAR is dropped; CLEAR aborts with no done pulse.
module yqc_calc_seq
    import yqc_calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       key,
    input  logic             key_vld,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             err
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    op_t              op_q;

    logic             clr_key;
    logic             exec_idle;
    logic             b_zero;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;

    logic             iter_start;
    logic             iter_last;
    logic             iter_hi_nz;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] iter_rem;

    logic             res_now;
    logic [WIDTH-1:0] res_val;
    logic             res_ovf;
    logic             res_err;
    logic             flag_clr;

    assign clr_key   = key_vld && (key == KEY_CLEAR);
    assign exec_idle = (state == IDLE) && key_vld && (key == KEY_EXEC);
    assign b_zero    = (reg_b == '0);
    assign add_sum   = {1'b0, reg_a} + {1'b0, reg_b};
    assign sub_diff  = {1'b0, reg_a} - {1'b0, reg_b};
    assign busy      = (state != IDLE);

    yqc_calc_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_key),
        .start     (iter_start),
        .op        (op_q),
        .a         (reg_a),
        .b         (reg_b),
        .res_lo    (iter_lo),
        .res_hi_nz (iter_hi_nz),
        .rem       (iter_rem),
        .last      (iter_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        iter_start = 1'b0;
        res_now    = 1'b0;
        res_val    = '0;
        res_ovf    = 1'b0;
        res_err    = 1'b0;
        flag_clr   = 1'b0;

        case (state)
            IDLE: begin
                if (exec_idle) begin
                    flag_clr = 1'b1;
                    case (op_q)
                        ADD: begin
                            res_now = 1'b1;
                            res_val = add_sum[WIDTH-1:0];
                            res_ovf = add_sum[WIDTH];
                        end
                        SUB: begin
                            res_now = 1'b1;
                            res_val = sub_diff[WIDTH-1:0];
                            res_ovf = sub_diff[WIDTH];
                        end
                        default: begin
                            // Division by zero is answered immediately instead of running the divider.
                            if (op_is_div(op_q) && b_zero) begin
                                res_now = 1'b1;
                                res_val = '1;
                                res_err = 1'b1;
                            end else begin
                                state_nxt  = CALC;
                                iter_start = 1'b1;
                            end
                        end
                    endcase
                end
            end
            CALC: begin
                if (iter_last) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                state_nxt = IDLE;
                res_now   = 1'b1;
                case (op_q)
                    MUL: begin
                        res_val = iter_lo;
                        res_ovf = iter_hi_nz;
                    end
                    DIV:     res_val = iter_lo;
                    default: res_val = iter_rem;
                endcase
            end
            default: state_nxt = IDLE;
        endcase

        if (clr_key) begin
            state_nxt  = IDLE;
            iter_start = 1'b0;
            res_now    = 1'b0;
            flag_clr   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_key) begin
            reg_a    <= '0;
            reg_b    <= '0;
            op_q     <= ADD;
            data_out <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= res_now;

            // Operands and op are only writable from IDLE, so they stay frozen during CALC/FIN.
            if ((state == IDLE) && key_vld) begin
                case (key)
                    KEY_LOAD_A: reg_a <= data_in;
                    KEY_LOAD_B: reg_b <= data_in;
                    KEY_OP_ADD: op_q  <= ADD;
                    KEY_OP_SUB: op_q  <= SUB;
                    KEY_OP_MUL: op_q  <= MUL;
                    KEY_OP_DIV: op_q  <= DIV;
                    KEY_OP_MOD: op_q  <= MOD;
                    default: ;
                endcase
            end

            if (flag_clr) begin
                ovf <= 1'b0;
                err <= 1'b0;
            end

            if (res_now) begin
                data_out <= res_val;
                ovf      <= res_ovf;
                err      <= res_err;
`ifdef YQC_CALC_CHAIN_EN
                reg_a    <= res_val;
`else
`endif
            end
        end
    end

endmodule
